// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter
// Description : Round-robin arbiter sharing one downstream resource among
//               N_REQ requesters. Registered one-hot grant plus encoded
//               index, highest-index-first search rotated by a pointer,
//               grant held while the owner requests, bounded by MAX_HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
  parameter int N_REQ    = 8,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Saturation value of the hold counter: MAX_HOLD, or all-ones when unlimited.
  localparam logic [CNT_W-1:0] HOLD_SAT  = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  PTR_RESET = ID_W'(N_REQ - 1);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [ID_W-1:0]    gnt_id_nxt;
  logic [CNT_W-1:0]   hold_nxt;

  logic [N_REQ-1:0]   cand;
  logic               found;
  logic [ID_W-1:0]    win;
  logic               own_req;
  logic               at_limit;
  logic               take;

  // Winner search: walk ptr, ptr-1, ..., 0, N_REQ-1, ... and take the first
  // candidate. While a grant is held the current owner is masked out so the
  // result is always "the next owner other than the current one".
  always_comb begin
    cand  = (state == GRANT) ? (req & ~gnt) : req;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin : search_loop
      int              idx;
      logic [ID_W-1:0] idx_v;
      idx = int'(ptr) - k;
      if (idx < 0) begin
        idx = idx + N_REQ;
      end
      idx_v = ID_W'(idx);
      if (!found && cand[idx_v]) begin
        found = 1'b1;
        win   = idx_v;
      end
    end
  end

  assign own_req  = req[gnt_id];
  assign at_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);

  // Next-state and next-output decision for the grant FSM.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    hold_nxt   = hold_cnt;
    ptr_nxt    = ptr;
    take       = 1'b0;

    case (state)
      IDLE: begin
        if (en && found) begin
          take = 1'b1;
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Owner released: hand over at the same edge when possible.
          if (en && found) begin
            take = 1'b1;
          end else begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            gnt_id_nxt = '0;
            hold_nxt   = '0;
          end
        end else if (at_limit && en && found) begin
          // Hold window exhausted and someone else is waiting: preempt.
          take = 1'b1;
        end else if (at_limit && !found) begin
          // Nobody else wants the resource: open a fresh hold window.
          hold_nxt = CNT_W'(1);
        end else if (hold_cnt != HOLD_SAT) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (take) begin
      state_nxt  = GRANT;
      gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << win;
      gnt_id_nxt = win;
      hold_nxt   = CNT_W'(1);
      ptr_nxt    = (win == '0) ? PTR_RESET : (win - ID_W'(1));
    end
  end

  // State, pointer and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_RESET;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_arbiter
// Description : Scoreboard bench for rr_grant_arbiter (N_REQ=8, MAX_HOLD=4).
//               Directed scenarios followed by randomized traffic, checked
//               against a cycle-level behavioural model of the arbiter rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

  localparam int N     = 8;
  localparam int ID_W  = 3;
  localparam int MH    = 4;
  localparam int CNT_W = 3;
  localparam int HMAX  = (MH == 0) ? ((1 << CNT_W) - 1) : MH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic [CNT_W-1:0] hold_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0]     g;
    logic [ID_W-1:0]  id;
    logic             v;
    logic [CNT_W-1:0] h;
  } exp_t;

  exp_t sb[$];

  // Reference model state: owner index (-1 = idle), pointer, hold count.
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_hold  = 0;

  rr_grant_arbiter #(
    .N_REQ(N), .ID_W(ID_W), .MAX_HOLD(MH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic has(input logic [N-1:0] r, input int i);
    return |(r & (8'h01 << i));
  endfunction

  // Candidate order: ptr down to 0, then N-1 down to ptr+1.
  function automatic int pick(input logic [N-1:0] r, input int p, input int excl);
    for (int i = p; i >= 0; i--)
      if (i != excl && has(r, i)) return i;
    for (int i = N - 1; i > p; i--)
      if (i != excl && has(r, i)) return i;
    return -1;
  endfunction

  task automatic take(input int w);
    m_owner = w;
    m_hold  = 1;
    m_ptr   = (w == 0) ? N - 1 : w - 1;
  endtask

  task automatic model_step(input logic r, input logic e, input logic [N-1:0] q);
    int   w;
    exp_t x;
    if (r) begin
      m_owner = -1; m_ptr = N - 1; m_hold = 0;
    end else if (m_owner < 0) begin
      w = pick(q, m_ptr, -1);
      if (e && w >= 0) take(w);
    end else begin
      w = pick(q, m_ptr, m_owner);
      if (!has(q, m_owner)) begin
        if (e && w >= 0) take(w);
        else begin m_owner = -1; m_hold = 0; end
      end else if (MH != 0 && m_hold == MH && e && w >= 0) begin
        take(w);
      end else if (MH != 0 && m_hold == MH) begin
        m_hold = (w < 0) ? 1 : MH;
      end else begin
        m_hold = (m_hold + 1 > HMAX) ? HMAX : m_hold + 1;
      end
    end
    x.g  = (m_owner < 0) ? '0 : (8'h01 << m_owner);
    x.id = (m_owner < 0) ? '0 : m_owner[ID_W-1:0];
    x.v  = (m_owner >= 0);
    x.h  = m_hold[CNT_W-1:0];
    sb.push_back(x);
  endtask

  // Drive one cycle of stimulus and record what the DUT must show after the edge.
  task automatic step(input logic r, input logic e, input logic [N-1:0] q);
    @(negedge clk);
    rst = r; en = e; req = q;
    model_step(r, e, q);
  endtask

  // Directed check with literal expectations, sampled just after the edge.
  task automatic check_now(input string name, input logic [N-1:0] eg,
                           input int eid, input int eh);
    @(posedge clk);
    #2;
    n_cmp++;
    if (gnt !== eg || gnt_id !== eid[ID_W-1:0] || gnt_valid !== (eg != '0) ||
        hold_cnt !== eh[CNT_W-1:0]) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h id=%0d valid=%b hold=%0d, want gnt=%h id=%0d valid=%b hold=%0d",
               name, gnt, gnt_id, gnt_valid, hold_cnt, eg, eid, (eg != '0), eh);
    end
  endtask

  // Monitor: every edge that has a pending expectation is compared against it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_cmp++;
        if (gnt !== x.g || gnt_id !== x.id || gnt_valid !== x.v || hold_cnt !== x.h) begin
          n_bad++;
          $display("FAIL sb t=%0t: got gnt=%h id=%0d valid=%b hold=%0d, want gnt=%h id=%0d valid=%b hold=%0d",
                   $time, gnt, gnt_id, gnt_valid, hold_cnt, x.g, x.id, x.v, x.h);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] q;
    logic         r, e;
    int           own;

    // Reset held with every request asserted.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'hFF);
      check_now("reset", 8'h00, 0, 0);
    end

    // Single requester, then release.
    step(0, 1, 8'h10); check_now("single_gnt", 8'h10, 4, 1);
    step(0, 1, 8'h00); check_now("single_rel", 8'h00, 0, 0);

    // Rotation: each owner drops its request for one cycle after being granted.
    step(1, 1, 8'h00);
    q = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step(0, 1, q);
      own = (7 - i + 8) % 8;
      check_now("rotate", 8'h01 << own, own, 1);
      q = 8'hFF & ~(8'h01 << own);
    end

    // Hold timeout with a competitor: 7 x4, 0 x4, 7.
    step(1, 1, 8'h00);
    for (int c = 0; c < 9; c++) begin
      step(0, 1, 8'h81);
      check_now("timeout", (c < 4 || c == 8) ? 8'h80 : 8'h01,
                (c < 4 || c == 8) ? 7 : 0, (c % 4) + 1);
    end

    // Hold timeout with no competitor: owner kept, counter wraps 4 -> 1.
    step(1, 1, 8'h00);
    for (int c = 0; c < 6; c++) begin
      step(0, 1, 8'h80);
      check_now("hold_wrap", 8'h80, 7, (c % 4) + 1);
    end

    // Enable gating.
    step(1, 1, 8'h00);
    step(0, 0, 8'h02); check_now("en_block", 8'h00, 0, 0);
    step(0, 1, 8'h02); check_now("en_grant", 8'h02, 1, 1);
    step(0, 0, 8'h02); check_now("en_keep1", 8'h02, 1, 2);
    step(0, 0, 8'h06); check_now("en_keep2", 8'h02, 1, 3);
    step(0, 0, 8'h04); check_now("en_release", 8'h00, 0, 0);

    // Mid-grant reset, then pointer back at N-1.
    step(1, 1, 8'h00);
    step(0, 1, 8'h08); check_now("mid_own", 8'h08, 3, 1);
    step(0, 1, 8'h08); check_now("mid_hold2", 8'h08, 3, 2);
    step(1, 1, 8'h08); check_now("mid_reset", 8'h00, 0, 0);
    step(0, 1, 8'h00); check_now("mid_idle", 8'h00, 0, 0);
    step(0, 1, 8'hFF); check_now("mid_ptr", 8'h80, 7, 1);

    // Randomized traffic; request patterns persist for a few cycles so that
    // hold windows expire and preemption is exercised.
    q = 8'h00;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       q = N'($urandom);
          1:       q = N'($urandom & $urandom);
          2:       q = 8'h01 << $urandom_range(0, N - 1);
          default: q = q ^ (8'h01 << $urandom_range(0, N - 1));
        endcase
      end
      step(r, e, q);
    end

    // Let the scoreboard drain, bounded.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
